// File: rtl/bus_xcvr_ctl.sv
// A-side sequencer for an octal bidirectional bus transceiver with active-low T_n/R_n enables.
// Optional A-side parity generation/checking is enabled by defining XCVR_PARITY_EN.

module bus_xcvr_ctl #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned DRIVE_CYC  = 2,
  parameter int unsigned SAMPLE_CYC = 2,
  parameter int unsigned TURN_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       req_write,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       ack,
  output logic [7:0] rdata,
  output logic [7:0] a_out,
  output logic       a_oe,
  input  logic [7:0] a_in,
  output logic       T_n,
`ifdef XCVR_PARITY_EN
  output logic       a_out_par,
  input  logic       a_in_par,
  output logic       perr,
`endif
  output logic       R_n
);

  // state    | meaning
  // IDLE     | all enables off, waiting for req
  // WR_SETUP | A driven, transceiver still disabled
  // WR_DRIVE | A driven, T_n low
  // RD_WAIT  | A released, R_n low; A captured on exit
  // TURN     | everything off so driver and receive path never overlap
  // DONE     | one-cycle ack
  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_DRIVE,
    RD_WAIT,
    TURN,
    DONE
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] DRIVE_LD  = 4'(DRIVE_CYC - 1);
  localparam logic [3:0] SAMPLE_LD = 4'(SAMPLE_CYC - 1);
  localparam logic [3:0] TURN_LD   = 4'(TURN_CYC - 1);

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      ack       <= 1'b0;
      a_oe      <= 1'b0;
      T_n       <= 1'b1;
      R_n       <= 1'b1;
      rdata     <= 8'h00;
      a_out     <= 8'h00;
`ifdef XCVR_PARITY_EN
      a_out_par <= 1'b1;
      perr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= 1'b0;
          if (req) begin
            busy  <= 1'b1;
            a_out <= wdata;
`ifdef XCVR_PARITY_EN
            a_out_par <= ~^wdata;
            perr      <= 1'b0;
`endif
            if (req_write) begin
              state <= WR_SETUP;
              a_oe  <= 1'b1;
              cnt   <= SETUP_LD;
            end else begin
              state <= RD_WAIT;
              R_n   <= 1'b0;
              cnt   <= SAMPLE_LD;
            end
          end
        end
        WR_SETUP: begin
          if (cnt == 4'd0) begin
            state <= WR_DRIVE;
            T_n   <= 1'b0;
            cnt   <= DRIVE_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_DRIVE: begin
          if (cnt == 4'd0) begin
            state <= TURN;
            T_n   <= 1'b1;
            a_oe  <= 1'b0;
            cnt   <= TURN_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            state <= TURN;
            R_n   <= 1'b1;
            rdata <= a_in;
`ifdef XCVR_PARITY_EN
            perr  <= ~(^{a_in, a_in_par});
`endif
            cnt   <= TURN_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        TURN: begin
          if (cnt == 4'd0) begin
            state <= DONE;
            ack   <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ack   <= 1'b0;
          a_oe  <= 1'b0;
          T_n   <= 1'b1;
          R_n   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xcvr_ctl.sv
// Bench for bus_xcvr_ctl: two instances (default timing and 2/3/1/3 timing) checked against a
// cycles-since-accept behavioural model, plus directed literal checks.

module tb_bus_xcvr_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1;
  logic       req[2], req_write[2];
  logic [7:0] wdata[2], a_in[2];
  logic       busy[2], ack[2], a_oe[2], T_n[2], R_n[2];
  logic [7:0] rdata[2], a_out[2];
`ifdef XCVR_PARITY_EN
  logic       a_out_par[2], a_in_par[2], perr[2];
`endif

  int tests = 0;
  int fails = 0;

  bus_xcvr_ctl u_dut0 (
    .clk(clk), .reset(rst0), .req(req[0]), .req_write(req_write[0]), .wdata(wdata[0]),
    .busy(busy[0]), .ack(ack[0]), .rdata(rdata[0]), .a_out(a_out[0]), .a_oe(a_oe[0]),
    .a_in(a_in[0]), .T_n(T_n[0]),
`ifdef XCVR_PARITY_EN
    .a_out_par(a_out_par[0]), .a_in_par(a_in_par[0]), .perr(perr[0]),
`endif
    .R_n(R_n[0])
  );

  bus_xcvr_ctl #(.SETUP_CYC(2), .DRIVE_CYC(3), .SAMPLE_CYC(1), .TURN_CYC(3)) u_dut1 (
    .clk(clk), .reset(rst1), .req(req[1]), .req_write(req_write[1]), .wdata(wdata[1]),
    .busy(busy[1]), .ack(ack[1]), .rdata(rdata[1]), .a_out(a_out[1]), .a_oe(a_oe[1]),
    .a_in(a_in[1]), .T_n(T_n[1]),
`ifdef XCVR_PARITY_EN
    .a_out_par(a_out_par[1]), .a_in_par(a_in_par[1]), .perr(perr[1]),
`endif
    .R_n(R_n[1])
  );

  // timing of each instance as seen by the model
  int s_c[2]  = '{1, 2};
  int d_c[2]  = '{2, 3};
  int sm_c[2] = '{2, 1};
  int tu_c[2] = '{1, 3};

  // model: a transfer is just "k cycles since accept"; outputs follow from k
  bit         m_act[2];
  int         m_k[2];
  bit         m_wr[2];
  logic [7:0] m_aout[2];
  logic [7:0] m_rd[2];
  bit         m_perr[2];

  function automatic int lat(int i, bit wr);
    return wr ? (s_c[i] + d_c[i] + tu_c[i]) : (sm_c[i] + tu_c[i]);
  endfunction

  function automatic void model_reset(int i);
    m_act[i]  = 1'b0;
    m_k[i]    = 0;
    m_wr[i]   = 1'b0;
    m_aout[i] = 8'h00;
    m_rd[i]   = 8'h00;
    m_perr[i] = 1'b0;
  endfunction

  function automatic void model_step(int i);
    if (!m_act[i]) begin
      if (req[i]) begin
        m_act[i]  = 1'b1;
        m_k[i]    = 1;
        m_wr[i]   = req_write[i];
        m_aout[i] = wdata[i];
        m_perr[i] = 1'b0;
      end
    end else begin
      if (!m_wr[i] && m_k[i] == sm_c[i]) begin
        m_rd[i] = a_in[i];
`ifdef XCVR_PARITY_EN
        m_perr[i] = ((^{a_in[i], a_in_par[i]}) != 1'b1);
`endif
      end
      if (m_k[i] == lat(i, m_wr[i]) + 1) m_act[i] = 1'b0;
      else m_k[i] = m_k[i] + 1;
    end
  endfunction

  always @(posedge clk or posedge rst0) begin
    if (rst0) model_reset(0);
    else model_step(0);
  end

  always @(posedge clk or posedge rst1) begin
    if (rst1) model_reset(1);
    else model_step(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!((i == 0) ? rst0 : rst1)) begin
        automatic bit wr_on = m_act[i] && m_wr[i] && m_k[i] <= s_c[i] + d_c[i];
        automatic bit tx_on = wr_on && m_k[i] > s_c[i];
        automatic bit rx_on = m_act[i] && !m_wr[i] && m_k[i] <= sm_c[i];
        automatic bit e_ack = m_act[i] && m_k[i] == lat(i, m_wr[i]) + 1;
        chk($sformatf("u%0d_busy", i), busy[i], m_act[i]);
        chk($sformatf("u%0d_ack", i), ack[i], e_ack);
        chk($sformatf("u%0d_a_oe", i), a_oe[i], wr_on);
        chk($sformatf("u%0d_T_n", i), T_n[i], !tx_on);
        chk($sformatf("u%0d_R_n", i), R_n[i], !rx_on);
        chk($sformatf("u%0d_a_out", i), a_out[i], m_aout[i]);
        chk($sformatf("u%0d_rdata", i), rdata[i], m_rd[i]);
        chk($sformatf("u%0d_contention_tr", i), (T_n[i] === 1'b0 && R_n[i] === 1'b0), 0);
        chk($sformatf("u%0d_contention_oe", i), (a_oe[i] === 1'b1 && R_n[i] === 1'b0), 0);
`ifdef XCVR_PARITY_EN
        chk($sformatf("u%0d_a_out_par", i), a_out_par[i], ~^m_aout[i]);
        chk($sformatf("u%0d_perr", i), perr[i], m_perr[i]);
`endif
      end
    end
  end

  // accept one transfer on instance 0 and wait (bounded) for ack; leaves us in the ack cycle
  task automatic run0(input bit wr, input logic [7:0] wd, input logic [7:0] ain,
                      input int exp_lat, input string nm);
    int n;
    @(posedge clk); #2;
    req[0] = 1'b1; req_write[0] = wr; wdata[0] = wd; a_in[0] = ain;
    @(posedge clk); #2;
    req[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack[0] !== 1'b1 && n < 30);
    chk(nm, n, exp_lat + 1);
  endtask

  task automatic seq0();
    int n;
    rst0 = 1'b1; req[0] = 1'b0; req_write[0] = 1'b0; wdata[0] = 8'h00; a_in[0] = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst0 = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_a_oe", a_oe[0], 0);
    chk("rst_T_n", T_n[0], 1);
    chk("rst_R_n", R_n[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_ack", ack[0], 0);
    chk("rst_rdata", rdata[0], 8'h00);

    // write A5, defaults
    @(posedge clk); #2;
    req[0] = 1'b1; req_write[0] = 1'b1; wdata[0] = 8'hA5;
    @(posedge clk); #2;
    req[0] = 1'b0; req_write[0] = 1'b0; wdata[0] = 8'h00;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("wr_c%0d_a_oe", c), a_oe[0], (c <= 3));
      chk($sformatf("wr_c%0d_T_n", c), T_n[0], !(c == 2 || c == 3));
      chk($sformatf("wr_c%0d_R_n", c), R_n[0], 1);
      chk($sformatf("wr_c%0d_ack", c), ack[0], (c == 5));
      chk($sformatf("wr_c%0d_busy", c), busy[0], (c <= 5));
      chk($sformatf("wr_c%0d_a_out", c), a_out[0], 8'hA5);
    end

    // read 3C, defaults
    @(posedge clk); #2;
    a_in[0] = 8'h3C; req[0] = 1'b1; req_write[0] = 1'b0;
    @(posedge clk); #2;
    req[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("rd_c%0d_R_n", c), R_n[0], !(c <= 2));
      chk($sformatf("rd_c%0d_a_oe", c), a_oe[0], 0);
      chk($sformatf("rd_c%0d_ack", c), ack[0], (c == 4));
      if (c >= 4) chk($sformatf("rd_c%0d_rdata", c), rdata[0], 8'h3C);
      if (c == 3) a_in[0] = 8'hFF;
    end

    // reset asserted in the middle of WR_DRIVE
    @(posedge clk); #2;
    req[0] = 1'b1; req_write[0] = 1'b1; wdata[0] = 8'h5A;
    @(posedge clk); #2;
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_T_n", T_n[0], 0);
    #1 rst0 = 1'b1;
    #1;
    chk("abort_T_n", T_n[0], 1);
    chk("abort_a_oe", a_oe[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_a_out", a_out[0], 8'h00);
    @(posedge clk); #2 rst0 = 1'b0;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack[0] === 1'b1) n++;
    end
    chk("abort_no_ack", n, 0);
    run0(1'b1, 8'hC3, 8'h00, 4, "post_abort_wr_lat");
    chk("post_abort_a_out", a_out[0], 8'hC3);

`ifdef XCVR_PARITY_EN
    a_in_par[0] = 1'b0;
    run0(1'b0, 8'h00, 8'h01, 3, "par_rd_lat");
    chk("par_rd_ok_perr", perr[0], 0);
    a_in_par[0] = 1'b1;
    run0(1'b0, 8'h00, 8'h01, 3, "par_rd2_lat");
    chk("par_rd_bad_perr", perr[0], 1);
    run0(1'b1, 8'h03, 8'h00, 4, "par_wr_lat");
    chk("par_wr_a_out_par", a_out_par[0], 1);
    chk("par_wr_perr", perr[0], 0);
`endif

    repeat (400) begin
      @(posedge clk); #2;
      req[0]       = ($urandom_range(0, 3) != 0);
      req_write[0] = 1'($urandom_range(0, 1));
      wdata[0]     = 8'($urandom);
      a_in[0]      = 8'($urandom);
`ifdef XCVR_PARITY_EN
      a_in_par[0]  = 1'($urandom_range(0, 1));
`endif
    end
    req[0] = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  // instance 1: req held high, alternating write/read
  task automatic seq1();
    int n;
    bit wr;
    rst1 = 1'b1; req[1] = 1'b0; req_write[1] = 1'b0; wdata[1] = 8'h00; a_in[1] = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    wr = 1'b1;
    req[1] = 1'b1; req_write[1] = wr; wdata[1] = 8'($urandom);
    for (int t = 0; t < 8; t++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy[1] !== 1'b1 && n < 30);
      chk("b2b_accept", busy[1], 1);
      req_write[1] = ~wr;
      wdata[1]     = 8'($urandom);
      a_in[1]      = 8'($urandom);
`ifdef XCVR_PARITY_EN
      a_in_par[1]  = 1'($urandom_range(0, 1));
`endif
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (ack[1] !== 1'b1 && n < 30);
      chk(wr ? "b2b_wr_lat" : "b2b_rd_lat", n, wr ? 8 : 4);
      @(negedge clk);
      chk("b2b_idle_gap", busy[1], 0);
      wr = ~wr;
    end
    #2 req[1] = 1'b0;
    repeat (12) @(posedge clk);
  endtask

  initial begin
`ifdef XCVR_PARITY_EN
    a_in_par[0] = 1'b0;
    a_in_par[1] = 1'b0;
`endif
    fork
      seq0();
      seq1();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
